// File: rtl/logic_gates_pipe_if.sv
// Operand/result bundle for logic_gates_pipe: producer handshake, consumer
// handshake, sweep control and status.
interface logic_gates_pipe_if #(parameter int WIDTH = 4);
  logic             mode;
  logic             start;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] y1;
  logic [WIDTH-1:0] y2;
  logic [WIDTH-1:0] y3;
  logic [WIDTH-1:0] y4;
  logic [WIDTH-1:0] y5;
  logic             busy;
  logic             done;

  modport master (
    output mode, start, in_valid, a, b, out_ready,
    input  in_ready, out_valid, a_q, b_q, y1, y2, y3, y4, y5, busy, done
  );

  modport slave (
    input  mode, start, in_valid, a, b, out_ready,
    output in_ready, out_valid, a_q, b_q, y1, y2, y3, y4, y5, busy, done
  );
endinterface

// File: rtl/logic_gates_pipe.sv
// Registered AND/OR/XOR/NAND/NOR of two WIDTH-bit operands with valid/ready
// flow control and a built-in exhaustive sweep sequencer.
module logic_gates_pipe #(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  logic_gates_pipe_if.slave  gp
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  localparam logic [WIDTH-1:0] MAXV = '1;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sa_q, sa_d, sb_q, sb_d;
  logic             ov_q, ov_d;
  logic [WIDTH-1:0] aq_q, bq_q, y1_q, y2_q, y3_q, y4_q, y5_q;

  logic             ext_sel, slot_free, src_valid, load;
  logic [WIDTH-1:0] src_a, src_b;

  // External operands are only routed in while idle in external mode, so a
  // producer's in_valid during a sweep is never consumed.
  assign ext_sel   = (state_q == IDLE) && !gp.mode;
  assign slot_free = !ov_q || gp.out_ready;
  assign src_valid = ext_sel ? gp.in_valid : (state_q == RUN);
  assign src_a     = ext_sel ? gp.a : sa_q;
  assign src_b     = ext_sel ? gp.b : sb_q;
  assign load      = src_valid && slot_free;

  always_comb begin
    state_d = state_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    case (state_q)
      IDLE: begin
        if (gp.start && gp.mode) begin
          state_d = RUN;
          sa_d    = '0;
          sb_d    = '0;
        end
      end
      RUN: begin
        // a leads, b catches up: (k,k-1) -> (k,k) -> (k+1,k); stop at (M,M).
        if (load) begin
          if (sa_q == sb_q) begin
            if (sa_q == MAXV) state_d = DONE;
            else              sa_d    = sa_q + WIDTH'(1);
          end else begin
            sb_d = sa_q;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      sa_q    <= '0;
      sb_q    <= '0;
    end else begin
      state_q <= state_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
    end
  end

  always_comb begin
    ov_d = ov_q;
    if (load)              ov_d = 1'b1;
    else if (gp.out_ready) ov_d = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ov_q <= 1'b0;
      aq_q <= '0;
      bq_q <= '0;
      y1_q <= '0;
      y2_q <= '0;
      y3_q <= '0;
      y4_q <= '0;
      y5_q <= '0;
    end else begin
      ov_q <= ov_d;
      if (load) begin
        aq_q <= src_a;
        bq_q <= src_b;
        y1_q <= src_a & src_b;
        y2_q <= src_a | src_b;
        y3_q <= src_a ^ src_b;
        y4_q <= ~(src_a & src_b);
        y5_q <= ~(src_a | src_b);
      end
    end
  end

  assign gp.in_ready  = !rst && ext_sel && slot_free;
  assign gp.out_valid = ov_q;
  assign gp.a_q       = aq_q;
  assign gp.b_q       = bq_q;
  assign gp.y1        = y1_q;
  assign gp.y2        = y2_q;
  assign gp.y3        = y3_q;
  assign gp.y4        = y4_q;
  assign gp.y5        = y5_q;
  assign gp.busy      = (state_q == RUN);
  assign gp.done      = (state_q == DONE);

endmodule

// File: tb/tb_logic_gates_pipe.sv
// Bench for logic_gates_pipe: table vectors, backpressure, sweeps (steady and
// random out_ready), reset mid-sweep, and a WIDTH=8 instance.
module tb_logic_gates_pipe;
  localparam int W = 4;
  localparam logic [W-1:0] M = '1;

  typedef struct packed {
    logic [W-1:0] a, b, y1, y2, y3, y4, y5;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic_gates_pipe_if #(.WIDTH(4)) bus ();
  logic_gates_pipe_if #(.WIDTH(8)) bus8 ();

  logic_gates_pipe #(.WIDTH(4)) dut  (.clk(clk), .rst(rst), .gp(bus));
  logic_gates_pipe #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .gp(bus8));

  int   checks = 0, failures = 0;
  int   pops = 0, busy_cnt = 0, done_cnt = 0;
  vec_t q[$];
  vec_t prev;
  logic hold = 1'b0;
  vec_t tbl[6];

  function automatic vec_t model(logic [W-1:0] a, logic [W-1:0] b);
    vec_t v;
    v.a = a; v.b = b;
    v.y1 = a & b; v.y2 = a | b; v.y3 = a ^ b;
    v.y4 = ~(a & b); v.y5 = ~(a | b);
    return v;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic mon();
    vec_t cur, e;
    if (rst) begin
      hold = 1'b0;
      return;
    end
    cur = {bus.a_q, bus.b_q, bus.y1, bus.y2, bus.y3, bus.y4, bus.y5};
    if (hold) chk("hold_stable", 32'(cur), 32'(prev));
    if (bus.busy) begin
      busy_cnt++;
      chk("in_ready_busy", 32'(bus.in_ready), 32'(0));
    end
    if (bus.done) begin
      done_cnt++;
      chk("done_last", 32'({bus.out_valid, bus.a_q, bus.b_q}), 32'({1'b1, M, M}));
    end
    if (bus.out_valid && bus.out_ready) begin
      if (q.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_result actual=%h expected=none", cur);
      end else begin
        e = q.pop_front();
        chk("result", 32'(cur), 32'(e));
        pops++;
      end
    end
    hold = bus.out_valid && !bus.out_ready;
    prev = cur;
  endtask

  task automatic send(vec_t e);
    bit got = 0;
    @(posedge clk); #1;
    bus.in_valid = 1'b1; bus.a = e.a; bus.b = e.b;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (bus.in_ready) begin q.push_back(e); got = 1; break; end
      @(posedge clk); #1;
    end
    if (!got) begin checks++; failures++; $display("FAIL send_timeout actual=0 expected=1"); end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic push_sweep();
    logic [W-1:0] a = '0, b = '0;
    for (int i = 0; i < 64; i++) begin
      q.push_back(model(a, b));
      if (a == b) begin
        if (a == M) break;
        a = a + 1'b1;
      end else b = a;
    end
  endtask

  task automatic drain(string name);
    for (int c = 0; c < 50 && q.size() != 0; c++) @(posedge clk);
    repeat (2) @(posedge clk);
    chk(name, 32'(q.size()), 32'(0));
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 bus.start = 1'b1;
    @(posedge clk); #1 bus.start = 1'b0;
  endtask

  task automatic wait_done(string name);
    for (int c = 0; c < 300 && done_cnt == 0; c++) @(posedge clk);
    chk(name, 32'(done_cnt), 32'(1));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    bus.mode = 0; bus.start = 0; bus.in_valid = 0; bus.a = '0; bus.b = '0; bus.out_ready = 1;
    bus8.mode = 0; bus8.start = 0; bus8.in_valid = 0; bus8.a = '0; bus8.b = '0; bus8.out_ready = 1;

    tbl[0] = '{a:4'hA, b:4'hC, y1:4'h8, y2:4'hE, y3:4'h6, y4:4'h7, y5:4'h1};
    tbl[1] = '{a:4'h0, b:4'h0, y1:4'h0, y2:4'h0, y3:4'h0, y4:4'hF, y5:4'hF};
    tbl[2] = '{a:4'hF, b:4'hF, y1:4'hF, y2:4'hF, y3:4'h0, y4:4'h0, y5:4'h0};
    tbl[3] = '{a:4'h5, b:4'hA, y1:4'h0, y2:4'hF, y3:4'hF, y4:4'hF, y5:4'h0};
    tbl[4] = '{a:4'h3, b:4'h6, y1:4'h2, y2:4'h7, y3:4'h5, y4:4'hD, y5:4'h8};
    tbl[5] = '{a:4'hF, b:4'h0, y1:4'h0, y2:4'hF, y3:4'hF, y4:4'hF, y5:4'h0};

    // reset state
    repeat (2) @(posedge clk); #1;
    chk("rst_out_valid", 32'(bus.out_valid), 32'(0));
    chk("rst_data", 32'({bus.a_q, bus.b_q, bus.y1, bus.y2, bus.y3, bus.y4, bus.y5}), 32'(0));
    chk("rst_busy_done", 32'({bus.busy, bus.done}), 32'(0));
    chk("rst_in_ready", 32'(bus.in_ready), 32'(0));
    @(negedge clk) rst = 1'b0;
    fork
      forever begin @(negedge clk); mon(); end
    join_none

    // table vectors, first one also checks one-cycle latency
    send(tbl[0]);
    @(negedge clk);
    chk("latency_out_valid", 32'(bus.out_valid), 32'(1));
    for (int i = 1; i < 6; i++) send(tbl[i]);
    drain("table_drain");

    // backpressure: second vector waits three cycles
    @(posedge clk); #1;
    bus.in_valid = 1; bus.a = 4'h1; bus.b = 4'h2; bus.out_ready = 1;
    @(negedge clk);
    chk("bp_accept1", 32'(bus.in_ready), 32'(1));
    q.push_back(model(4'h1, 4'h2));
    @(posedge clk); #1;
    bus.a = 4'h3; bus.b = 4'h4; bus.out_ready = 0;
    repeat (3) begin
      @(negedge clk);
      chk("bp_in_ready_low", 32'(bus.in_ready), 32'(0));
      chk("bp_hold", 32'({bus.out_valid, bus.a_q, bus.b_q}), 32'({1'b1, 4'h1, 4'h2}));
      @(posedge clk); #1;
    end
    bus.out_ready = 1;
    @(negedge clk);
    chk("bp_accept2", 32'(bus.in_ready), 32'(1));
    q.push_back(model(4'h3, 4'h4));
    @(posedge clk); #1;
    bus.in_valid = 0;
    @(negedge clk);
    chk("bp_second_out", 32'({bus.out_valid, bus.a_q, bus.b_q}), 32'({1'b1, 4'h3, 4'h4}));
    drain("bp_drain");

    // sweep with steady out_ready; external in_valid must be ignored
    push_sweep();
    busy_cnt = 0; done_cnt = 0;
    bus.mode = 1; bus.in_valid = 1; bus.a = 4'h5; bus.b = 4'h5;
    pulse_start();
    wait_done("sweep1_done");
    drain("sweep1_drain");
    chk("sweep1_busy_cycles", 32'(busy_cnt), 32'(31));
    chk("sweep1_done_pulses", 32'(done_cnt), 32'(1));
    bus.in_valid = 0;

    // sweep with random out_ready and a stray second start
    push_sweep();
    done_cnt = 0;
    pulse_start();
    for (int c = 0; c < 1000 && done_cnt == 0; c++) begin
      @(posedge clk); #1;
      bus.out_ready = 1'($urandom_range(0, 1));
      bus.start = (c == 6);
    end
    bus.start = 0; bus.out_ready = 1;
    drain("sweep2_drain");
    chk("sweep2_done_pulses", 32'(done_cnt), 32'(1));

    // reset after the 10th sweep result, then restart from (0,0)
    push_sweep();
    base = pops;
    pulse_start();
    for (int c = 0; c < 100 && pops < base + 10; c++) @(posedge clk);
    chk("rst_mid_count", 32'(pops - base), 32'(10));
    #1 rst = 1'b1;
    #1;
    chk("rst_mid_data", 32'({bus.out_valid, bus.a_q, bus.b_q, bus.y1, bus.y2, bus.y3, bus.y4, bus.y5}), 32'(0));
    chk("rst_mid_status", 32'({bus.busy, bus.done, bus.in_ready}), 32'(0));
    q.delete();
    @(negedge clk) rst = 1'b0;
    push_sweep();
    done_cnt = 0;
    pulse_start();
    wait_done("sweep3_done");
    drain("sweep3_drain");
    bus.mode = 0;

    // WIDTH=8 instance
    @(posedge clk); #1;
    bus8.in_valid = 1; bus8.a = 8'hFF; bus8.b = 8'h0F;
    @(negedge clk);
    chk("w8_in_ready", 32'(bus8.in_ready), 32'(1));
    @(posedge clk); #1;
    bus8.in_valid = 0;
    @(negedge clk);
    chk("w8_valid", 32'(bus8.out_valid), 32'(1));
    chk("w8_y", 32'({bus8.y1, bus8.y2, bus8.y3, bus8.y4, bus8.y5}),
        32'({8'h0F, 8'hFF, 8'hF0, 8'hF0, 8'h00}));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/logic_gates_pipe.md
# logic_gates_pipe

Parametrised, registered successor to the 4-bit combinational gate set: computes AND, OR, XOR, NAND and NOR of two WIDTH-bit operands through one pipeline register with valid/ready flow control. A built-in sweep sequencer can replace the external operand source. It walks a and b alternately through every value, so the gate set is exhaustively exercised in hardware without a bench driving stimulus. It sits between an operand producer and a result consumer, or stands alone as a self-exercising gate checker.

## Interface
- WIDTH, 4, operand and result width in bits (≥1)
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- mode  in  1  0 = external operands, 1 = internal sweep; sampled only in IDLE
- start  in  1  pulse; begins a sweep when in IDLE with mode=1
- in_valid  in  1  external operand valid (mode=0)
- in_ready  out  1  external operand accepted when in_valid & in_ready
- a, b  in  WIDTH  external operands
- out_valid  out  1  result register holds a valid result
- out_ready  in  1  consumer accepts result when out_valid & out_ready
- a_q, b_q  out  WIDTH  operands that produced the current result
- y1  out  WIDTH  a & b
- y2  out  WIDTH  a | b
- y3  out  WIDTH  a ^ b
- y4  out  WIDTH  ~(a & b)
- y5  out  WIDTH  ~(a | b)
- busy  out  1  high while the sweep sequencer is in RUN
- done  out  1  one-cycle pulse when a sweep finishes

## Operation
- Pipeline register loads when `load = src_valid & (!out_valid | out_ready)`.
  - src_valid = in_valid in external mode, or the sequencer's valid in RUN.
  - On load, a_q/b_q/y1..y5 take the new values and out_valid=1.
  - Otherwise, if out_ready is high, out_valid clears. If out_ready is low, everything holds.
- in_ready = !reset & (state==IDLE) & (mode==0) & (!out_valid | out_ready). in_ready is forced 0 during a sweep.
- Sequencer states: IDLE, RUN, DONE.
  - IDLE -> RUN on start & mode. Operands are set to (a=0, b=0).
  - RUN presents the current pair with valid=1. On each load it advances to the next pair.
  - Sweep order: (0,0),(1,0),(1,1),(2,1),(2,2),…,(M,M−1),(M,M), where M = 2^WIDTH−1. If a==b, a increments; otherwise b increments (b := a).
  - Total sweep length is 2^(WIDTH+1)−1 vectors.
  - RUN -> DONE on the load of (M,M). No wrap-around; the pair counters never overflow.
  - DONE -> IDLE after one cycle. done=1 only in DONE.
- start in RUN or DONE is ignored. mode changes outside IDLE are ignored.
- External in_valid during a sweep is ignored; no operand is consumed.
- All results are pure bitwise functions, WIDTH bits wide. There is no carry and no sign.

## Timing
- Reset (async assert; deassert synchronised by the system):
  - out_valid=0, a_q=b_q=y1..y5=0, busy=0, done=0, state=IDLE.
  - in_ready=0 while reset is high.
- Latency: one cycle from an accepted operand to out_valid with its result.
- Throughput: one vector per cycle while out_ready stays high.
- Backpressure: while out_valid & !out_ready, all outputs are stable and no new operand loads.
- busy=1 in every RUN cycle, beginning the cycle after start is sampled.
- done rises the cycle after the (M,M) load, the same cycle its result first shows on out_valid.
- Reset mid-sweep aborts immediately:
  - The result in flight is discarded (out_valid=0).
  - The next start restarts at (0,0).
- Simultaneous load and out_ready in the same cycle: the old result is consumed and the new one replaces it. There is no bubble.

## Test plan
- External, WIDTH=4, a=0xA, b=0xC, out_ready=1 -> next cycle: out_valid=1, y1=0x8, y2=0xE, y3=0x6, y4=0x7, y5=0x1, a_q=0xA, b_q=0xC.
- Backpressure: two back-to-back vectors with out_ready low for 3 cycles after the first.
  - The first result holds for 3 cycles and in_ready=0 throughout.
  - The second vector loads in the cycle out_ready returns. Nothing is lost or duplicated.
- Sweep, WIDTH=4, out_ready=1 -> 31 consecutive results from (0,0) to (F,F) in the documented order.
  - busy is high for 31 cycles, done pulses once, and in_ready=0 throughout.
  - Every y1..y5 matches the bitwise model.
- Sweep with random out_ready -> the same 31 ordered vectors with no gaps or repeats. A second start during RUN has no effect.
- Reset asserted after the 10th sweep result -> outputs zero and state IDLE at once. A new start yields (0,0) first.
- External, WIDTH=8, a=0xFF, b=0x0F -> y1=0x0F, y2=0xFF, y3=0xF0, y4=0xF0, y5=0x00.
